imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_ack.sv | 25 ++
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared encodings for the instruction-memory image loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      SYNC = 3'd0,
      LEN0 = 3'd1,
      LEN1 = 3'd2,
      DATA = 3'd3,
      CSUM = 3'd4,
      DONE = 3'd5
   } state_t;

   localparam logic [7:0] ACK_OK    = 8'h4B;
   localparam logic [7:0] ACK_ERR   = 8'h45;
   localparam logic [7:0] ACK_TMO   = 8'h54;
   localparam logic [7:0] DEF_MAGIC = 8'hA5;

endpackage

// File: rtl/imem_loader_ack.sv
// Single-entry ack byte holder with a valid/ready handshake.
module imem_loader_ack (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       tx_ready,
   output logic       tx_valid,
   output logic [7:0] tx_data
);

   // A new ack overwrites one still pending.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
      end else if (push) begin
         tx_valid <= 1'b1;
         tx_data  <= push_data;
      end else if (tx_valid && tx_ready) begin
         tx_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Parses a framed firmware image from a byte stream and writes it
// into instruction memory, holding the core in reset until loaded.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         ADDR_WIDTH     = 10,
   parameter int         TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0] MAGIC          = DEF_MAGIC
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [16:0]   CAP   = 17'(1) << ADDR_WIDTH;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state;
   state_t        state_n;
   logic [TW-1:0] tmo_cnt;
   logic [15:0]   len;
   logic [15:0]   widx;
   logic [23:0]   asm_q;
   logic [1:0]    bidx;
   logic [7:0]    csum;
   logic [15:0]   len_full;
   logic          in_frame;
   logic          tmo_hit;
   logic          last_byte;
   logic          last_word;
   logic          ack_push;
   logic [7:0]    ack_byte;
   logic          err_set;
   logic          err_clr;

   assign in_frame  = state inside {LEN0, LEN1, DATA, CSUM};
   assign tmo_hit   = in_frame && !rx_valid && (tmo_cnt == TLAST);
   assign len_full  = {rx_data, len[7:0]};
   assign last_byte = (bidx == 2'd3);
   assign last_word = (widx == len - 16'd1);

   assign busy       = in_frame;
   assign done       = (state == DONE);
   assign core_reset = (state != DONE);

   always_ff @(posedge clk) begin
      if (reset) state <= SYNC;
      else       state <= state_n;
   end

   always_comb begin
      state_n  = state;
      ack_push = 1'b0;
      ack_byte = ACK_ERR;
      err_set  = 1'b0;
      err_clr  = 1'b0;
      if (tmo_hit) begin
         state_n  = SYNC;
         ack_push = 1'b1;
         ack_byte = ACK_TMO;
         err_set  = 1'b1;
      end else if (rx_valid) begin
         unique case (state)
            SYNC: if (rx_data == MAGIC) state_n = LEN0;
            LEN0: state_n = LEN1;
            LEN1: begin
               if ({1'b0, len_full} > CAP) begin
                  state_n  = SYNC;
                  ack_push = 1'b1;
                  err_set  = 1'b1;
               end else if (len_full == 16'd0) begin
                  state_n = CSUM;
               end else begin
                  state_n = DATA;
               end
            end
            DATA: if (last_byte && last_word) state_n = CSUM;
            CSUM: begin
               ack_push = 1'b1;
               if (rx_data == csum) begin
                  state_n  = DONE;
                  ack_byte = ACK_OK;
                  err_clr  = 1'b1;
               end else begin
                  state_n = SYNC;
                  err_set = 1'b1;
               end
            end
            DONE:    state_n = DONE;
            default: state_n = SYNC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt    <= '0;
         len        <= 16'd0;
         widx       <= 16'd0;
         asm_q      <= 24'd0;
         bidx       <= 2'd0;
         csum       <= 8'd0;
         error      <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'd0;
      end else begin
         imem_we <= 1'b0;
         if (err_set)      error <= 1'b1;
         else if (err_clr) error <= 1'b0;
         if (!in_frame || rx_valid || tmo_hit) tmo_cnt <= '0;
         else                                  tmo_cnt <= tmo_cnt + 1'b1;
         if (rx_valid) begin
            unique case (state)
               LEN0: len[7:0] <= rx_data;
               LEN1: begin
                  len[15:8] <= rx_data;
                  csum      <= 8'd0;
                  bidx      <= 2'd0;
                  widx      <= 16'd0;
               end
               DATA: begin
                  csum <= csum + rx_data;
                  bidx <= bidx + 2'd1;
                  // Little-endian: earlier bytes shift toward bit 0.
                  if (last_byte) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= widx[ADDR_WIDTH-1:0];
                     imem_wdata <= {rx_data, asm_q};
                     widx       <= widx + 16'd1;
                  end else begin
                     asm_q <= {rx_data, asm_q[23:8]};
                  end
               end
               default: ;
            endcase
         end
      end
   end

   imem_loader_ack u_ack (
      .clk       (clk),
      .reset     (reset),
      .push      (ack_push),
      .push_data (ack_byte),
      .tx_ready  (tx_ready),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data)
   );

endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed bench for imem_loader against a frame-level model.
module tb_imem_loader;

   localparam int AW  = 10;
   localparam int TC  = 50;
   localparam int CAP = 1 << AW;

   logic          clk      = 1'b0;
   logic          reset    = 1'b1;
   logic [7:0]    rx_data  = 8'h00;
   logic          rx_valid = 1'b0;
   logic          tx_ready = 1'b1;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_reset;
   logic          busy;
   logic          done;
   logic          error;

   imem_loader #(
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (TC),
      .MAGIC          (8'hA5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          a;
      logic [31:0] d;
   } wr_t;
   typedef logic [7:0] byte_q_t[$];

   wr_t        exp_w[$];
   logic [7:0] exp_tx[$];
   bit         m_done;
   bit         m_err;
   bit         rnd_ready;
   int         total;
   int         bad;
   wr_t        cw;
   logic [7:0] ct;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         chk("core_reset_vs_done", {31'd0, core_reset}, {31'd0, !done});
         if (imem_we) begin
            if (exp_w.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write got addr=%h data=%h want none",
                        imem_addr, imem_wdata);
            end else begin
               cw = exp_w.pop_front();
               chk("write_addr", 32'(imem_addr), cw.a);
               chk("write_data", imem_wdata, cw.d);
            end
         end
         if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_ack got=%h want none", tx_data);
            end else begin
               ct = exp_tx.pop_front();
               chk("ack_byte", 32'(tx_data), 32'(ct));
            end
         end
      end
   end

   // Frame-level reference: what a whole byte sequence must produce.
   task automatic predict(input byte_q_t fr, input bit tmo);
      int          n;
      int          nb;
      logic [7:0]  s;
      logic [31:0] w;
      n  = int'({fr[2], fr[1]});
      nb = fr.size() - 3;
      if (n > CAP) begin
         exp_tx.push_back(8'h45);
         m_err = 1'b1;
         return;
      end
      for (int i = 0; i < n && 4 * i + 3 < nb; i++) begin
         w = {fr[6 + 4 * i], fr[5 + 4 * i], fr[4 + 4 * i], fr[3 + 4 * i]};
         exp_w.push_back('{a: i, d: w});
      end
      if (nb > 4 * n) begin
         s = 8'd0;
         for (int i = 0; i < 4 * n; i++) s = s + fr[3 + i];
         if (fr[3 + 4 * n] == s) begin
            exp_tx.push_back(8'h4B);
            m_done = 1'b1;
            m_err  = 1'b0;
         end else begin
            exp_tx.push_back(8'h45);
            m_err = 1'b1;
         end
      end else if (tmo) begin
         exp_tx.push_back(8'h54);
         m_err = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_byte(input logic [7:0] b, input int gmax);
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      repeat ($urandom_range(0, gmax)) step();
   endtask

   task automatic send_q(input byte_q_t fr, input int gmax);
      foreach (fr[i]) send_byte(fr[i], gmax);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp_w.size() != 0 || exp_tx.size() != 0) && k < 300) begin
         step();
         k++;
      end
      total++;
      if (k >= 300) begin
         bad++;
         $display("FAIL drain got pending w=%0d tx=%0d want 0",
                  exp_w.size(), exp_tx.size());
         exp_w.delete();
         exp_tx.delete();
      end
      repeat (3) step();
   endtask

   task automatic check_flags(input string nm);
      chk({nm, "_done"}, {31'd0, done}, {31'd0, m_done});
      chk({nm, "_error"}, {31'd0, error}, {31'd0, m_err});
      chk({nm, "_core_reset"}, {31'd0, core_reset}, {31'd0, !m_done});
      chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
      chk({nm, "_tx_data"}, 32'(tx_data), 32'd0);
      chk({nm, "_imem_we"}, {31'd0, imem_we}, 32'd0);
      chk({nm, "_imem_addr"}, 32'(imem_addr), 32'd0);
      chk({nm, "_imem_wdata"}, imem_wdata, 32'd0);
      chk({nm, "_core_reset"}, {31'd0, core_reset}, 32'd1);
      chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
      chk({nm, "_done"}, {31'd0, done}, 32'd0);
      chk({nm, "_error"}, {31'd0, error}, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset  = 1'b0;
      m_done = 1'b0;
      m_err  = 1'b0;
   endtask

   task automatic run_frame(input byte_q_t fr, input int gmax,
                            input string nm);
      predict(fr, 1'b0);
      send_q(fr, gmax);
      drain();
      check_flags(nm);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1);
   end

   initial begin
      byte_q_t    f;
      byte_q_t    g;
      int         n;
      int         k;
      logic [7:0] s;
      logic [7:0] gb;
      total     = 0;
      bad       = 0;
      rnd_ready = 1'b0;
      m_done    = 1'b0;
      m_err     = 1'b0;
      step();
      step();
      check_reset_vals("rst");
      reset = 1'b0;
      step();

      f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
      predict(f, 1'b0);
      chk("pin_w0_addr", exp_w[0].a, 32'd0);
      chk("pin_w0_data", exp_w[0].d, 32'h0000_0013);
      chk("pin_w1_addr", exp_w[1].a, 32'd1);
      chk("pin_w1_data", exp_w[1].d, 32'h0010_0093);
      chk("pin_ack_ok", 32'(exp_tx[0]), 32'h4B);
      send_q(f, 2);
      drain();
      check_flags("load2");
      send_q(f, 0);
      drain();
      check_flags("done_ignores");
      do_reset();

      f[11] = 8'h00;
      run_frame(f, 1, "bad_csum");
      chk("bad_csum_err", {31'd0, error}, 32'd1);
      f[11] = 8'hB6;
      run_frame(f, 0, "resend");
      do_reset();

      g = '{8'h00, 8'hFF, 8'h12};
      send_q(g, 1);
      f = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
      predict(f, 1'b0);
      chk("pin_garb_data", exp_w[0].d, 32'h0403_0201);
      send_q(f, 1);
      drain();
      check_flags("garbage");
      do_reset();

      f = '{8'hA5, 8'h01, 8'h04};
      predict(f, 1'b0);
      chk("pin_big_ack", 32'(exp_tx[0]), 32'h45);
      chk("pin_big_nowr", exp_w.size(), 32'd0);
      send_q(f, 0);
      drain();
      check_flags("too_big");
      f = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
      run_frame(f, 0, "after_big");
      do_reset();

      f = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
      predict(f, 1'b1);
      chk("pin_tmo_ack", 32'(exp_tx[0]), 32'h54);
      send_q(f, 0);
      drain();
      check_flags("timeout");
      f = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
      predict(f, 1'b0);
      for (int i = 0; i < 6; i++) send_byte(f[i], 0);
      repeat (TC - 1) step();
      chk("near_tmo_busy", {31'd0, busy}, 32'd1);
      send_byte(f[6], 0);
      send_byte(f[7], 0);
      drain();
      check_flags("near_tmo");
      do_reset();

      f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
      predict(f, 1'b0);
      tx_ready = 1'b0;
      send_q(f, 0);
      k = 0;
      while (!tx_valid && k < 100) begin
         step();
         k++;
      end
      chk("stall_rise", {31'd0, tx_valid}, 32'd1);
      repeat (20) begin
         step();
         chk("stall_valid", {31'd0, tx_valid}, 32'd1);
         chk("stall_data", 32'(tx_data), 32'h4B);
      end
      tx_ready = 1'b1;
      drain();
      check_flags("stall");
      do_reset();
      f = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
            8'h05, 8'h06};
      predict(f, 1'b0);
      send_q(f, 0);
      step();
      reset = 1'b1;
      step();
      check_reset_vals("midrst");
      step();
      reset  = 1'b0;
      m_done = 1'b0;
      m_err  = 1'b0;
      g = '{8'h07, 8'h08, 8'h00};
      send_q(g, 0);
      repeat (20) step();
      drain();
      check_flags("midrst_after");

      rnd_ready = 1'b1;
      for (int it = 0; it < 40; it++) begin
         f.delete();
         repeat ($urandom_range(0, 3)) begin
            do gb = 8'($urandom); while (gb == 8'hA5);
            send_byte(gb, 1);
         end
         if ($urandom_range(0, 9) == 0) begin
            n = $urandom_range(CAP + 1, 4000);
            f = '{8'hA5, 8'(n), 8'(n >> 8)};
         end else begin
            n = $urandom_range(0, 6);
            f = '{8'hA5, 8'(n), 8'h00};
            s = 8'd0;
            for (int i = 0; i < 4 * n; i++) begin
               gb = 8'($urandom);
               f.push_back(gb);
               s = s + gb;
            end
            if ($urandom_range(0, 2) == 0) s = s + 8'($urandom_range(1, 255));
            f.push_back(s);
         end
         run_frame(f, 3, "rnd");
         if (m_done) do_reset();
      end
      rnd_ready = 1'b0;
      tx_ready  = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
